// File: rtl/uart_boot_pkg.sv
// Shared definitions for the UART boot loader: UART-lite register map, status bits,
// phase and bus state encodings.
package uart_boot_pkg;

    localparam logic [31:0] UART_STAT_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_RXD_OFS  = 32'h0000_0004;
    localparam logic [31:0] UART_TXD_OFS  = 32'h0000_0008;

    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_TX_FULL  = 0;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        PH_SYNC,
        PH_LEN,
        PH_DATA,
        PH_CSUM,
        PH_DONE,
        PH_ERROR
    } phase_t;

    typedef enum logic [1:0] {
        BUS_STAT,
        BUS_DATA,
        BUS_WR,
        BUS_HALT
    } bus_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles popped payload bytes into a little-endian 32-bit word; the strobe bit of
// a lane is set once that lane has been written since the last clear.
module boot_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  lane,
    input  logic        push,
    input  logic        clear,
    output logic [31:0] word,
    output logic [3:0]  wstrb
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] byte_reg;
            logic       strb_reg;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    byte_reg <= 8'h00;
                    strb_reg <= 1'b0;
                end else if (push && (lane == 2'(gi))) begin
                    byte_reg <= byte_in;
                    strb_reg <= 1'b1;
                end
            end

            assign word[8*gi +: 8] = byte_reg;
            assign wstrb[gi]       = strb_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader bus master: polls a UART-lite slave, decodes magic/length/payload frames
// and writes the payload to memory. Define UART_BOOT_CHECKSUM_EN for a trailing sum byte.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter logic [31:0] UART_BASE = 32'h1000_0000,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_BYTES = 32'd65536,
    parameter logic [7:0]  MAGIC     = DEFAULT_MAGIC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        u_valid,
    input  logic        u_ready,
    output logic [31:0] u_addr,
    input  logic [31:0] u_rdata,
    output logic [31:0] u_wdata,
    output logic [3:0]  u_wstrb,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        busy,
    output logic        boot_done,
    output logic        boot_error
);

`ifdef UART_BOOT_CHECKSUM_EN
    localparam phase_t PH_TAIL = PH_CSUM;
`else
    localparam phase_t PH_TAIL = PH_DONE;
`endif

    bus_state_t  bus_reg, bus_next;
    phase_t      phase_reg, phase_next;
    logic        u_valid_reg, u_valid_next;
    logic [31:0] u_addr_reg, u_addr_next;
    logic        m_valid_reg, m_valid_next;
    logic [31:0] m_addr_reg, m_addr_next;
    logic [31:0] len_reg, len_next;
    logic [1:0]  len_idx_reg, len_idx_next;
    logic [31:0] cnt_reg, cnt_next;
`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0]  sum_reg, sum_next;
`endif

    logic [7:0]  rx_byte;
    logic [31:0] len_asm;
    logic        byte_pop;
    logic        wr_done;
    logic        wr_needed;
    logic        pack_push;
    logic        pack_clear;
    logic        rdata_hi_unused;

    assign rx_byte         = u_rdata[7:0];
    assign rdata_hi_unused = ^u_rdata[31:8];
    assign byte_pop        = (bus_reg == BUS_DATA) && u_valid_reg && u_ready;
    assign wr_done         = (bus_reg == BUS_WR) && m_valid_reg && m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_reg     <= BUS_STAT;
            phase_reg   <= PH_SYNC;
            u_valid_reg <= 1'b0;
            u_addr_reg  <= 32'h0;
            m_valid_reg <= 1'b0;
            m_addr_reg  <= 32'h0;
            len_reg     <= 32'h0;
            len_idx_reg <= 2'd0;
            cnt_reg     <= 32'h0;
`ifdef UART_BOOT_CHECKSUM_EN
            sum_reg     <= 8'h00;
`endif
        end else begin
            bus_reg     <= bus_next;
            phase_reg   <= phase_next;
            u_valid_reg <= u_valid_next;
            u_addr_reg  <= u_addr_next;
            m_valid_reg <= m_valid_next;
            m_addr_reg  <= m_addr_next;
            len_reg     <= len_next;
            len_idx_reg <= len_idx_next;
            cnt_reg     <= cnt_next;
`ifdef UART_BOOT_CHECKSUM_EN
            sum_reg     <= sum_next;
`endif
        end
    end

    always_comb begin
        bus_next     = bus_reg;
        phase_next   = phase_reg;
        u_valid_next = u_valid_reg;
        u_addr_next  = u_addr_reg;
        m_valid_next = m_valid_reg;
        m_addr_next  = m_addr_reg;
        len_next     = len_reg;
        len_idx_next = len_idx_reg;
        cnt_next     = cnt_reg;
        wr_needed    = 1'b0;
        pack_push    = 1'b0;
        pack_clear   = 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
        sum_next     = sum_reg;
`endif

        len_asm = len_reg;
        case (len_idx_reg)
            2'd0:    len_asm[7:0]   = rx_byte;
            2'd1:    len_asm[15:8]  = rx_byte;
            2'd2:    len_asm[23:16] = rx_byte;
            default: len_asm[31:24] = rx_byte;
        endcase

        // Phase logic advances once per popped byte.
        if (byte_pop) begin
            case (phase_reg)
                PH_SYNC: begin
                    if (rx_byte == MAGIC) begin
                        phase_next   = PH_LEN;
                        len_next     = 32'h0;
                        len_idx_next = 2'd0;
`ifdef UART_BOOT_CHECKSUM_EN
                        sum_next     = 8'h00;
`endif
                    end
                end
                PH_LEN: begin
                    len_next     = len_asm;
                    len_idx_next = len_idx_reg + 2'd1;
                    if (len_idx_reg == 2'd3) begin
                        if (len_asm > MAX_BYTES) begin
                            phase_next = PH_ERROR;
                        end else if (len_asm == 32'h0) begin
                            phase_next = PH_TAIL;
                        end else begin
                            phase_next = PH_DATA;
                            cnt_next   = 32'h0;
                        end
                    end
                end
                PH_DATA: begin
                    pack_push   = 1'b1;
                    cnt_next    = cnt_reg + 32'd1;
                    m_addr_next = BASE_ADDR + {cnt_reg[31:2], 2'b00};
                    wr_needed   = (cnt_reg[1:0] == 2'd3) || (cnt_next == len_reg);
`ifdef UART_BOOT_CHECKSUM_EN
                    sum_next    = sum_reg + rx_byte;
`endif
                end
`ifdef UART_BOOT_CHECKSUM_EN
                PH_CSUM: begin
                    phase_next = (rx_byte == sum_reg) ? PH_DONE : PH_ERROR;
                end
`endif
                default: ;
            endcase
        end

        // Leaving DATA waits for the last word's write so boot_done never precedes it.
        if (wr_done) begin
            pack_clear = 1'b1;
            if (cnt_reg == len_reg) begin
                phase_next = PH_TAIL;
            end
        end

        case (bus_reg)
            BUS_STAT: begin
                if (!u_valid_reg) begin
                    u_valid_next = 1'b1;
                    u_addr_next  = UART_BASE + UART_STAT_OFS;
                end else if (u_ready) begin
                    u_valid_next = 1'b0;
                    if (!u_rdata[STAT_RX_EMPTY]) begin
                        bus_next = BUS_DATA;
                    end
                end
            end
            BUS_DATA: begin
                if (!u_valid_reg) begin
                    u_valid_next = 1'b1;
                    u_addr_next  = UART_BASE + UART_RXD_OFS;
                end else if (u_ready) begin
                    u_valid_next = 1'b0;
                    if ((phase_next == PH_DONE) || (phase_next == PH_ERROR)) begin
                        bus_next = BUS_HALT;
                    end else if (wr_needed) begin
                        bus_next = BUS_WR;
                    end else begin
                        bus_next = BUS_STAT;
                    end
                end
            end
            BUS_WR: begin
                if (!m_valid_reg) begin
                    m_valid_next = 1'b1;
                end else if (m_ready) begin
                    m_valid_next = 1'b0;
                    bus_next     = (phase_next == PH_DONE) ? BUS_HALT : BUS_STAT;
                end
            end
            default: ;
        endcase
    end

    boot_word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .byte_in (rx_byte),
        .lane    (cnt_reg[1:0]),
        .push    (pack_push),
        .clear   (pack_clear),
        .word    (m_wdata),
        .wstrb   (m_wstrb)
    );

    assign u_valid    = u_valid_reg;
    assign u_addr     = u_addr_reg;
    assign u_wdata    = 32'h0;
    assign u_wstrb    = 4'h0;
    assign m_valid    = m_valid_reg;
    assign m_addr     = m_addr_reg;
    assign busy       = (phase_reg == PH_LEN) || (phase_reg == PH_DATA) || (phase_reg == PH_CSUM);
    assign boot_done  = (phase_reg == PH_DONE);
    assign boot_error = (phase_reg == PH_ERROR);

endmodule
